inta_sequencer: RTL

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/inta_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/inta_sequencer.sv
// INTA bus-cycle sequencer for an 8259-style interrupt controller: synchronizes inta_n and
// drives vector bytes onto the CPU data bus. Define MODE_8080_EN to add the 3-pulse 8080 CALL sequence.
module inta_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       int_req,
    input  logic [2:0] int_vec,
    input  logic [7:0] icw2,
    input  logic [2:0] icw1_addr,
    input  logic       upm,
    input  logic       aeoi,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       ack_strobe,
    output logic       eoi_strobe,
    output logic       spurious,
    output logic       abort,
    output logic       busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef MODE_8080_EN
    typedef enum logic [2:0] {IDLE, P1, G1, P2, G2, P3} state_t;
`else
    typedef enum logic [2:0] {IDLE, P1, G1, P2} state_t;
`endif

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   inta_s;
    logic                   inta_d;
    logic                   fall;
    logic                   rise;
    logic [CW-1:0]          cnt;
    logic [2:0]             vec_l;
    logic [7:0]             icw2_l;
    logic                   spur_l;
    logic                   aeoi_l;

`ifdef MODE_8080_EN
    logic                   mode_l;
    logic [2:0]             icw1_l;
`else
    logic                   unused_cfg;
    assign unused_cfg = ^{upm, icw1_addr, icw2_l[2:0]};
`endif

    assign inta_s = sync[SYNC_STAGES-1];
    assign fall   = inta_d & ~inta_s;
    assign rise   = ~inta_d & inta_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '1;
            inta_d <= 1'b1;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], inta_n};
            inta_d <= inta_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_out   <= '0;
            data_oe    <= 1'b0;
            ack_strobe <= 1'b0;
            eoi_strobe <= 1'b0;
            spurious   <= 1'b0;
            abort      <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            vec_l      <= '0;
            icw2_l     <= '0;
            spur_l     <= 1'b0;
            aeoi_l     <= 1'b0;
`ifdef MODE_8080_EN
            mode_l     <= 1'b1;
            icw1_l     <= '0;
`endif
        end else begin
            ack_strobe <= 1'b0;
            eoi_strobe <= 1'b0;
            spurious   <= 1'b0;
            abort      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state      <= P1;
                        busy       <= 1'b1;
                        vec_l      <= int_req ? int_vec : 3'b111;
                        icw2_l     <= icw2;
                        spur_l     <= ~int_req;
                        aeoi_l     <= aeoi;
                        ack_strobe <= int_req;
                        spurious   <= ~int_req;
`ifdef MODE_8080_EN
                        mode_l <= upm;
                        icw1_l <= icw1_addr;
                        if (!upm) begin
                            data_out <= 8'hCD;
                            data_oe  <= 1'b1;
                        end
`endif
                    end
                end
                P1: begin
                    if (rise) begin
                        state   <= G1;
                        data_oe <= 1'b0;
                        cnt     <= '0;
                    end
                end
                G1: begin
                    // Expiry is checked before a coincident fall, so that fall is dropped.
                    if (cnt >= LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        abort   <= 1'b1;
                        data_oe <= 1'b0;
                        cnt     <= '0;
                    end else if (fall) begin
                        state    <= P2;
                        cnt      <= '0;
                        data_oe  <= 1'b1;
                        data_out <= {icw2_l[7:3], vec_l};
`ifdef MODE_8080_EN
                        if (!mode_l) data_out <= {icw1_l, vec_l, 2'b00};
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                P2: begin
                    if (rise) begin
                        data_oe <= 1'b0;
`ifdef MODE_8080_EN
                        if (!mode_l) begin
                            state <= G2;
                            cnt   <= '0;
                        end else begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            eoi_strobe <= aeoi_l & ~spur_l;
                        end
`else
                        state      <= IDLE;
                        busy       <= 1'b0;
                        eoi_strobe <= aeoi_l & ~spur_l;
`endif
                    end
                end
`ifdef MODE_8080_EN
                G2: begin
                    if (cnt >= LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        abort   <= 1'b1;
                        data_oe <= 1'b0;
                        cnt     <= '0;
                    end else if (fall) begin
                        state    <= P3;
                        cnt      <= '0;
                        data_oe  <= 1'b1;
                        data_out <= icw2_l;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                P3: begin
                    if (rise) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        data_oe    <= 1'b0;
                        eoi_strobe <= aeoi_l & ~spur_l;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
